// File: rtl/pc_next_unit.sv
// rtl/pc_next_unit.sv - PC register, next-PC selection, N/Z flags and misaligned-transfer trap
module pc_next_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] EXC_VECTOR = 32'h0000_0080
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        status0,
  input  logic        status1,
  input  logic        status2,
  input  logic        flag_we,
  input  logic        halt,
  input  logic        alu_zero,
  input  logic [31:0] alu_result,
  input  logic [31:0] imm_ext,
  input  logic [25:0] jtarget,
  input  logic [31:0] rs_data,
  input  logic [31:0] mem_data,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        link_en,
  output logic        flag_n,
  output logic        flag_z,
  output logic        misalign_err
);

  typedef enum logic [2:0] {
    CLS_SEQ   = 3'b000,
    CLS_BMN   = 3'b001,
    CLS_BRZ   = 3'b010,
    CLS_BZ    = 3'b011,
    CLS_JMOR  = 3'b100,
    CLS_JALM  = 3'b101,
    CLS_JSPAL = 3'b110,
    CLS_BEQ   = 3'b111
  } cls_t;

  cls_t        cls;
  logic [31:0] bt;
  logic [31:0] jt;
  logic [31:0] np;

  assign cls      = cls_t'({status2, status1, status0});
  assign pc_plus4 = pc + 32'd4;
  assign bt       = pc_plus4 + {imm_ext[29:0], 2'b00};
  assign jt       = {pc_plus4[31:28], jtarget, 2'b00};
  assign link_en  = (cls == CLS_JALM) || (cls == CLS_JSPAL);

  // Flag branches read the registered flags, so an R-format result only
  // steers the instruction after it.
  always_comb begin
    np = pc_plus4;
    case (cls)
      CLS_SEQ:   np = pc_plus4;
      CLS_BMN:   np = flag_n ? mem_data : pc_plus4;
      CLS_BRZ:   np = flag_z ? rs_data : pc_plus4;
      CLS_BZ:    np = flag_z ? jt : pc_plus4;
      CLS_JMOR:  np = mem_data;
      CLS_JALM:  np = mem_data;
      CLS_JSPAL: np = jt;
      CLS_BEQ:   np = alu_zero ? bt : pc_plus4;
      default:   np = pc_plus4;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc           <= RESET_PC;
      flag_n       <= 1'b0;
      flag_z       <= 1'b0;
      misalign_err <= 1'b0;
    end else if (!halt) begin
      if (np[1:0] != 2'b00) begin
        pc           <= EXC_VECTOR;
        misalign_err <= 1'b1;
      end else begin
        pc <= np;
      end
      if (flag_we) begin
        flag_z <= (alu_result == 32'd0);
        flag_n <= alu_result[31];
      end
    end
  end

endmodule

// File: doc/pc_next_unit.md
# pc_next_unit

Program-counter and next-PC stage of the single-cycle MIPS datapath. It consumes the 3-bit branch/jump class code produced by the main control decoder (status2..status0) together with the ALU, register-file and data-memory results. It holds the PC register and the N/Z condition flags used by the custom flag branches. It also produces the link value (PC+4) for jalm and jspal, and traps misaligned control transfers to an exception vector.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC value after reset.
- EXC_VECTOR, 32'h0000_0080, PC loaded on a misaligned target.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- status0, status1, status2  input  1 each  class code {status2,status1,status0}; 000 sequential, 001 bmn, 010 brz, 011 bz, 100 jmor, 101 jalm, 110 jspal, 111 beq.
- flag_we  input  1  R-format result present; driven from the decoder's regdest.
- halt  input  1  hold PC and flags this cycle.
- alu_zero  input  1  ALU zero output, used by beq.
- alu_result  input  32  ALU result, source of the N/Z flags.
- imm_ext  input  32  sign-extended 16-bit immediate.
- jtarget  input  26  instruction bits [25:0].
- rs_data  input  32  register-file read port 1.
- mem_data  input  32  data-memory read data.
- pc  output  32  current PC; instruction-memory address.
- pc_plus4  output  32  pc + 4; link value for jalm and jspal.
- link_en  output  1  high when the class is jalm (101) or jspal (110).
- flag_n, flag_z  output  1 each  registered condition flags.
- misalign_err  output  1  sticky; set on the first trapped transfer.

## Operation
- pc_plus4 = pc + 4, computed modulo 2^32.
- Branch target bt = pc_plus4 + (imm_ext << 2), modulo 2^32.
- Jump target jt = {pc_plus4[31:28], jtarget, 2'b00}.
- Next-PC selection (np):
  - 000: np = pc_plus4.
  - 111 beq: np = bt if alu_zero, else pc_plus4.
  - 001 bmn: np = mem_data if flag_n, else pc_plus4.
  - 010 brz: np = rs_data if flag_z, else pc_plus4.
  - 011 bz: np = jt if flag_z, else pc_plus4.
  - 100 jmor: np = mem_data, unconditional.
  - 101 jalm: np = mem_data, unconditional, link_en = 1.
  - 110 jspal: np = jt, unconditional, link_en = 1.
- Misalignment: if np[1:0] != 2'b00, pc loads EXC_VECTOR and misaligned_err sets; it stays set until reset. Only mem_data and rs_data targets can be misaligned.
- Flag update: when flag_we = 1 and halt = 0, the edge loads flag_z = (alu_result == 0) and flag_n = alu_result[31]. Otherwise the flags hold.
- Halt: when halt = 1, pc, the flags and misalign_err all hold. link_en still reflects the current class combinationally.
- Class code is decoded combinationally; no class is latched.

## Timing
- Reset (synchronous, checked on the clk edge, highest priority): pc = RESET_PC, flag_n = 0, flag_z = 0, misalign_err = 0.
- Reset asserted mid-instruction discards np and any pending flag update in that cycle.
- One instruction per cycle. pc updates on every rising edge unless reset or halt is active.
- Conditional branches use the flags registered before the current edge. An R-format instruction's flags become visible to the next instruction, never the same one.
- Flag-branch code with flag_we = 1 in the same cycle is not a legal decoder output. If it occurs: the branch uses the old flags and the flags still update.
- Latency: np is combinational from all inputs and is registered into pc on the next edge. pc_plus4 and link_en are combinational from pc and the class code.
- pc = 32'hFFFF_FFFC with code 000: next pc = 0 (wrap-around); no error.

## Test plan
- Reset then 3 cycles of code 000 -> pc sequence 0, 4, 8, 12. Flags 0, misalign_err 0.
- beq: pc = 0x10, imm_ext = 0xFFFF_FFFE, alu_zero = 1 -> pc = 0x0C. Repeat with alu_zero = 0 -> pc = 0x14.
- Flag pipeline: flag_we = 1, alu_result = 0 (flag_z = 1), then brz with rs_data = 0x400 -> pc = 0x400. Then flag_we = 1, alu_result = 0x8000_0000, then bmn with mem_data = 0x200 -> pc = 0x200 and flag_z = 0.
- jalm at pc = 0x40, mem_data = 0x1000 -> link_en = 1, pc_plus4 = 0x44, next pc = 0x1000. jspal at pc = 0x3000_0010, jtarget = 0x10 -> next pc = 0x3000_0040, link_en = 1.
- jmor with mem_data = 0x1002 -> pc = 0x80, misalign_err = 1. Still 1 after 5 further cycles of code 000. Cleared only by reset.
- halt = 1 for 2 cycles during a bz with flag_z = 1 -> pc and flags frozen. Reset asserted together with halt and flag_we -> pc = 0, flags 0.
